// File: rtl/irq_input_conditioner_if.sv
// rtl/irq_input_conditioner_if.sv - Wishbone register bus shared by the IRQ input conditioner and its master
interface wb_bus;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, sel, addr, wdata,
    input  rdata, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, addr, wdata,
    output rdata, ack, err
  );
endinterface

// File: rtl/irq_input_conditioner.sv
// rtl/irq_input_conditioner.sv - per-line synchronizer, debounce and edge-pulse stage ahead of the IRQ controller
module irq_input_conditioner #(
  parameter logic [31:0] BaseAddr = 32'h4020
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [15:0] raw_lines_in,
  output logic [15:0] irq_lines_out,
  wb_bus.slave        bus_slave
);

  localparam int NumLines = 16;

  logic [15:0] rise_en_q, rise_en_d;
  logic [15:0] fall_en_q, fall_en_d;
  logic [15:0] db_en_q,   db_en_d;
  logic [7:0]  db_len_q,  db_len_d;

  logic [15:0] sync1_q, sync2_q;
  logic [15:0] filt_q, filt_d;
  logic [15:0] filt_prev_q;
  logic [7:0]  cnt_q [NumLines];
  logic [7:0]  cnt_d [NumLines];

  logic        access;
  logic        wr_ok;
  logic        hit_rise, hit_fall, hit_db_en, hit_db_len, hit_level;
  logic [15:0] lane_mask;
  logic [7:0]  db_lim;
  logic        db_active;
  logic        unused_bus_bits;

  assign unused_bus_bits = ^{bus_slave.wdata[31:16], bus_slave.sel[3:2]};

  // Bus decode: exact word addresses only, anything else is unmapped.
  assign access     = bus_slave.cyc & bus_slave.stb;
  assign hit_rise   = (bus_slave.addr == BaseAddr);
  assign hit_fall   = (bus_slave.addr == BaseAddr + 32'h4);
  assign hit_db_en  = (bus_slave.addr == BaseAddr + 32'h8);
  assign hit_db_len = (bus_slave.addr == BaseAddr + 32'hC);
  assign hit_level  = (bus_slave.addr == BaseAddr + 32'h10);
  assign lane_mask  = {{8{bus_slave.sel[1]}}, {8{bus_slave.sel[0]}}};

  assign bus_slave.err = access & bus_slave.we &
                         ((bus_slave.sel[1:0] == 2'b00) | hit_level);
  assign bus_slave.ack = access & ~bus_slave.err;
  assign wr_ok         = access & bus_slave.we & ~bus_slave.err;

  always_comb begin
    bus_slave.rdata = 32'h0;
    if (access && !bus_slave.we) begin
      if (hit_rise)   bus_slave.rdata = {16'h0, rise_en_q};
      if (hit_fall)   bus_slave.rdata = {16'h0, fall_en_q};
      if (hit_db_en)  bus_slave.rdata = {16'h0, db_en_q};
      if (hit_db_len) bus_slave.rdata = {24'h0, db_len_q};
      if (hit_level)  bus_slave.rdata = {16'h0, filt_q};
    end
  end

  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    db_en_d   = db_en_q;
    db_len_d  = db_len_q;
    if (wr_ok) begin
      if (hit_rise)
        rise_en_d = (rise_en_q & ~lane_mask) | (bus_slave.wdata[15:0] & lane_mask);
      if (hit_fall)
        fall_en_d = (fall_en_q & ~lane_mask) | (bus_slave.wdata[15:0] & lane_mask);
      if (hit_db_en)
        db_en_d = (db_en_q & ~lane_mask) | (bus_slave.wdata[15:0] & lane_mask);
      if (hit_db_len && bus_slave.sel[0])
        db_len_d = bus_slave.wdata[7:0];
    end
  end

  // A glitch shorter than db_len cycles clears the count; >= lets a lowered limit flip at once.
  assign db_lim    = db_len_q - 8'd1;
  assign db_active = (db_len_q != 8'd0);

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NumLines; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!db_en_q[i] || !db_active) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = 8'd0;
      end else if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] >= db_lim) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      rise_en_q   <= 16'h0;
      fall_en_q   <= 16'h0;
      db_en_q     <= 16'h0;
      db_len_q    <= 8'h0;
      sync1_q     <= 16'h0;
      sync2_q     <= 16'h0;
      filt_q      <= 16'h0;
      filt_prev_q <= 16'h0;
      for (int i = 0; i < NumLines; i++) cnt_q[i] <= 8'd0;
    end else begin
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      db_en_q     <= db_en_d;
      db_len_q    <= db_len_d;
      sync1_q     <= raw_lines_in;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      for (int i = 0; i < NumLines; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Registers only on the data path; the enables are applied combinationally so clearing one masks a pulse at once.
  assign irq_lines_out = (rise_en_q & filt_q & ~filt_prev_q) |
                         (fall_en_q & ~filt_q & filt_prev_q);

endmodule

// File: tb/tb_irq_input_conditioner.sv
// tb/tb_irq_input_conditioner.sv - directed scoreboard bench for irq_input_conditioner
module tb_irq_input_conditioner;
  localparam logic [31:0] Base = 32'h4020;
  localparam logic [31:0] ARise = Base;
  localparam logic [31:0] AFall = Base + 32'h4;
  localparam logic [31:0] ADbEn = Base + 32'h8;
  localparam logic [31:0] ADbLen = Base + 32'hC;
  localparam logic [31:0] ALevel = Base + 32'h10;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [15:0] raw;
  logic [15:0] irq;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  wb_bus bus ();

  irq_input_conditioner #(.BaseAddr(Base)) dut (
    .clk_in       (clk),
    .reset_in     (reset_in),
    .raw_lines_in (raw),
    .irq_lines_out(irq),
    .bus_slave    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic push_n(input string tag, input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) push(tag, v);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
        chk(tag_q.pop_front(), {16'h0, irq}, {16'h0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic exp_ack, input logic exp_err, input string tag);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
    bus.addr = a; bus.wdata = d; bus.sel = s;
    #1;
    chk({tag, "_ack"}, {31'h0, bus.ack}, {31'h0, exp_ack});
    chk({tag, "_err"}, {31'h0, bus.err}, {31'h0, exp_err});
    @(posedge clk);
    #1;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] expv, input string tag);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0;
    bus.addr = a; bus.sel = 4'hF;
    #1;
    chk({tag, "_ack"}, {31'h0, bus.ack}, 32'h1);
    chk({tag, "_rdata"}, bus.rdata, expv);
    bus.cyc = 1'b0; bus.stb = 1'b0;
    #1;
    chk({tag, "_idle_rdata"}, bus.rdata, 32'h0);
  endtask

  initial begin
    reset_in = 1'b0;
    raw = 16'hFFFF;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.sel = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;

    // Reset defaults
    push_n("rst_hold", 4, 16'h0);
    run(4);
    wb_read(ALevel, 32'h0, "level_in_reset");
    reset_in = 1'b1;
    push_n("rst_release", 3, 16'h0);
    run(3);
    wb_read(ALevel, 32'hFFFF, "level_after_reset");
    wb_read(ARise, 32'h0, "rise_default");
    wb_read(AFall, 32'h0, "fall_default");
    wb_read(ADbEn, 32'h0, "dben_default");
    wb_read(ADbLen, 32'h0, "dblen_default");
    raw = 16'h0;
    push_n("settle_low", 5, 16'h0);
    run(5);

    // Rising edge on line 3, no pulse on the fall
    wb_write(ARise, 32'h0008, 4'h3, 1'b1, 1'b0, "wr_rise3");
    raw = 16'h0008;
    push("rise3", 16'h0); push("rise3", 16'h0); push("rise3", 16'h0008);
    push_n("rise3_after", 2, 16'h0);
    run(5);
    raw = 16'h0;
    push_n("rise3_nofall", 5, 16'h0);
    run(5);

    // Both edges on line 15, five cycles apart
    wb_write(ARise, 32'h8000, 4'h3, 1'b1, 1'b0, "wr_rise15");
    wb_write(AFall, 32'h8000, 4'h3, 1'b1, 1'b0, "wr_fall15");
    raw = 16'h8000;
    push_n("both15", 2, 16'h0); push("both15_rise", 16'h8000);
    push_n("both15", 4, 16'h0); push("both15_fall", 16'h8000);
    push_n("both15_after", 2, 16'h0);
    run(5);
    raw = 16'h0;
    run(5);

    // Debounce on line 0 with length 4
    wb_write(ARise, 32'h0001, 4'h3, 1'b1, 1'b0, "wr_rise0");
    wb_write(AFall, 32'h0000, 4'h3, 1'b1, 1'b0, "wr_fall0");
    wb_write(ADbEn, 32'h0001, 4'h3, 1'b1, 1'b0, "wr_dben0");
    wb_write(ADbLen, 32'h0004, 4'h1, 1'b1, 1'b0, "wr_dblen4");
    raw = 16'h0001;
    push_n("glitch3", 8, 16'h0);
    run(3);
    raw = 16'h0;
    run(5);
    wb_read(ALevel, 32'h0, "level_after_glitch");
    raw = 16'h0001;
    push_n("db4", 5, 16'h0); push("db4_pulse", 16'h0001); push_n("db4_after", 2, 16'h0);
    run(4);
    raw = 16'h0;
    run(4);
    wb_read(ALevel, 32'h0001, "level_db_high");
    push_n("db4_fall", 6, 16'h0);
    run(6);
    wb_read(ALevel, 32'h0, "level_db_low");

    // Bus errors, byte lanes and unmapped accesses
    wb_write(ALevel, 32'h1234, 4'h3, 1'b0, 1'b1, "wr_level");
    wb_write(ARise, 32'hFFFF, 4'h1, 1'b1, 1'b0, "wr_rise_lane0");
    wb_read(ARise, 32'h00FF, "rise_lane0");
    wb_write(ARise, 32'hFFFF, 4'hC, 1'b0, 1'b1, "wr_sel_upper");
    wb_read(ARise, 32'h00FF, "rise_unchanged");
    wb_read(Base + 32'h20, 32'h0, "rd_unmapped");
    wb_write(Base + 32'h20, 32'hFFFF, 4'h3, 1'b1, 1'b0, "wr_unmapped");
    wb_write(ADbLen, 32'h0000, 4'h2, 1'b1, 1'b0, "wr_dblen_lane1");
    wb_read(ADbLen, 32'h0004, "dblen_lane1_ignored");

    // Lowering DB_LEN mid-count flips on the following edge
    wb_write(ARise, 32'h0004, 4'h3, 1'b1, 1'b0, "wr_rise2");
    wb_write(ADbEn, 32'h0004, 4'h3, 1'b1, 1'b0, "wr_dben2");
    wb_write(ADbLen, 32'h000A, 4'h1, 1'b1, 1'b0, "wr_dblen10");
    raw = 16'h0004;
    push_n("mid_count", 6, 16'h0);
    run(6);
    wb_write(ADbLen, 32'h0003, 4'h1, 1'b1, 1'b0, "wr_dblen3");
    push("mid_flip", 16'h0004);
    push_n("mid_after", 3, 16'h0);
    run(4);
    wb_read(ALevel, 32'h0004, "level_mid_flip");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_input_conditioner.md
# irq_input_conditioner

Per-line conditioning stage for up to 16 external interrupt sources, placed directly upstream of the external IRQ controller. Each raw input passes through a 2-flop synchronizer, an optional debounce filter and a programmable edge detector. The results are single-cycle pulses on `irq_lines_out`, which drive the controller's `irq_lines_in`. Configuration is done over a Wishbone slave port.

## Interface
- `BaseAddr`, `32'h4020`, byte address of the first register; registers are word-spaced.
- `clk_in`  input  1  system clock.
- `reset_in`  input  1  reset; synchronous, active-low.
- `raw_lines_in`  input  16  asynchronous external IRQ sources.
- `irq_lines_out`  output  16  conditioned one-cycle pulses to the IRQ controller.
- `bus_slave`  wb_bus.slave  —  Wishbone slave using `cyc`, `stb`, `we`, `sel`, `addr`, `wdata`, `rdata`, `ack`, `err`.

## Operation
- Registers (all reset to 0; only the listed bits exist, the rest read 0):
  - +0x0 `RISE_EN[15:0]`: enables rising-edge pulses per line.
  - +0x4 `FALL_EN[15:0]`: enables falling-edge pulses per line.
  - +0x8 `DB_EN[15:0]`: enables debounce per line.
  - +0xC `DB_LEN[7:0]`: shared debounce length in cycles.
  - +0x10 `LEVEL[15:0]`: read-only filtered line levels.
- Bus access:
  - Access is `cyc & stb`. `ack = access & ~err`. Both `ack` and `err` are combinational, in the same cycle as the access.
  - `err` is raised for a write with `sel[1:0]==0`, or for any write to LEVEL.
  - Writes honour byte lanes `sel[1:0]`, using the mask `{sel[1]?FF:00, sel[0]?FF:00}`. DB_LEN uses `sel[0]` only.
  - Writes to unmapped addresses are acked and ignored.
  - Reads always ack. `rdata` carries the register value, is 0 for unmapped addresses, and is 0 when there is no read access.
- Synchronizer, per line: `s1 <= raw`, `s2 <= s1`.
- Debounce, per line, with 8-bit counter `cnt` and register `filt`:
  - If `DB_EN[i]==0` or `DB_LEN==0`: `filt <= s2`, `cnt <= 0`.
  - Else, if `s2==filt`: `cnt <= 0`.
  - Else, if `cnt >= DB_LEN-1`: `filt <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Net effect: `filt` follows `s2` only after `s2` has differed from `filt` for `DB_LEN` consecutive cycles. Any glitch shorter than that resets the count.
- Edge detect, per line, with register `filt_d <= filt`:
  - `irq_lines_out[i] = (RISE_EN[i] & filt & ~filt_d) | (FALL_EN[i] & ~filt & filt_d)`.
  - The output is a combination of registers only, so it is glitch-free.
  - With both enables set, a pulse occurs on every transition.
- Config writes take effect in the cycle after the write's clock edge. The `>=` comparison means lowering `DB_LEN` mid-count flips immediately if the count is already past the new limit.

## Timing
- Reset: all registers, `s1`, `s2`, `filt`, `filt_d` and `cnt` are 0. `irq_lines_out` is 0 in the cycle after the reset edge. `ack`/`err` stay combinational and follow the bus during reset.
- Undebounced latency, for raw stable before edge k:
  - `s1` at edge k, `s2` at k+1, `filt` at k+2.
  - `irq_lines_out` is high from k+2 to k+3: exactly one cycle.
- Debounced latency: `filt` updates at edge k+1+`DB_LEN`. The pulse follows one cycle later for one cycle.
- Back-to-back transitions give one pulse per `filt` change. The minimum pulse spacing is 1 cycle when undebounced and `DB_LEN` cycles when debounced.
- Clearing `DB_EN[i]` zeroes `cnt[i]` on the next edge.
- Clearing a `RISE_EN`/`FALL_EN` bit suppresses a pulse in the same cycle, because the output is combinational on the enable.
- Reset asserted mid-count or mid-pulse aborts the operation. A line held high through reset release does not pulse, because `RISE_EN` is 0.

## Test plan
- **Reset defaults:** hold `reset_in`=0 with `raw`=FFFF, then release. Required: `irq_lines_out`=0 throughout, LEVEL reads FFFF after 3 cycles, and all config registers read 0.
- **Rising edge, line 3:** write RISE_EN=0x0008, then drive raw[3] 0→1 before edge k. Required: `irq_lines_out`=0x0008 for exactly the cycle k+2..k+3, and no pulse on 1→0.
- **Both edges:** RISE_EN=FALL_EN=0x8000; raw[15] toggles high for 5 cycles. Required: two 1-cycle pulses on bit 15, 5 cycles apart.
- **Debounce:** DB_EN=0x0001, DB_LEN=4.
  - A 3-cycle high glitch on raw[0] gives no pulse and LEVEL[0] stays 0.
  - A 4-cycle high gives `filt` at k+5 and a pulse k+5..k+6.
- **Bus errors and lanes:**
  - Write LEVEL: `err`=1, `ack`=0.
  - Write RISE_EN with `sel`=0b0001 and wdata=FFFF: reads back 0x00FF.
  - Write with `sel`=0b1100: `err`=1.
  - Read of unmapped +0x20: `ack`=1, `rdata`=0.
- **Mid-count DB_LEN change:** DB_LEN=10, raw[2] high with DB_EN[2]=1. After 6 cycles write DB_LEN=3. Required: `filt`[2] flips on the next edge.
